seq_gen_stream: RTL and testbench
=================================

// Module: seq_gen_stream
// PURPOSE
//  Parametrised arithmetic sequence generator with a valid/ready output stream.
//  Successor to the single-mode generator: adds configurable width, STOP/WRAP/BOUNCE
//  modes, an optional beat limit, backpressure, abort and config error checking.
//  Sits between a config/control master and any stream consumer (DSP, stimulus path).
// PARAMETERS
//  WIDTH  32  data width; start_value/step/range_min/range_max/out_data are signed WIDTH
//  CNT_W  16  width of beat counter and count_max
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous reset, active-low
//  start        in   1      start request; sampled only in IDLE
//  abort        in   1      abandon current run; has priority over everything except reset
//  mode         in   2      0=STOP, 1=WRAP, 2=BOUNCE, 3=reserved (config error)
//  start_value  in   WIDTH  first value (signed)
//  step         in   WIDTH  signed increment; 0 is a config error
//  range_min    in   WIDTH  inclusive lower bound (signed)
//  range_max    in   WIDTH  inclusive upper bound (signed)
//  count_max    in   CNT_W  beat limit; 0 = unlimited
//  out_valid    out  1      out_data valid
//  out_ready    in   1      consumer accepts beat
//  out_data     out  WIDTH  current sequence value
//  out_last     out  1      current beat is the final one
//  busy         out  1      high in LOAD and RUN
//  done         out  1      one-cycle pulse when a run ends (normal or error)
//  err          out  1      one-cycle pulse with done on config error
// BEHAVIOUR
//  Reset: state IDLE; out_valid, out_data, out_last, busy, done, err = 0; internal regs = 0.
//  Config inputs are latched into shadow registers when start is accepted in IDLE;
//  changes after that are ignored until the next run.
//  FSM: IDLE -start-> LOAD -> RUN -last handshake-> DONE -> IDLE (DONE lasts 1 cycle).
//   LOAD: validate config. Error if step==0, mode==3, range_min>range_max, or
//   start_value outside [range_min,range_max]. On error: DONE with done=1, err=1; no beat emitted.
//   Otherwise cur<=start_value, dir<=+1, beats<=0, go to RUN.
//  Latency: start seen at edge E0 -> busy=1; at E1 -> out_valid=1, out_data=start_value.
//  RUN: out_valid=1, out_data=cur. A beat transfers when out_valid&&out_ready.
//   Beat is held stable (data, last) while out_ready=0.
//  Next-value arithmetic uses WIDTH+1 bits signed: nxt = cur + dir*step (no overflow).
//   STOP:   beat is last if nxt outside range; next = nxt otherwise.
//   WRAP:   nxt>range_max -> range_min; nxt<range_min -> range_max; else nxt.
//   BOUNCE: if nxt is out of range, flip dir and use cur - dir*step;
//           if that is also out of range, hold cur.
//  Beat limit: beat is also last when count_max!=0 and beats==count_max-1;
//   the counter increments per handshake and saturates.
//  out_last is registered and valid together with out_data.
//  On the handshake of the last beat: out_valid<=0, go to DONE, done=1 for one cycle.
//  abort (any state): next edge -> IDLE; out_valid, out_last, busy <= 0; done not pulsed.
//  Simultaneous start and abort in IDLE: abort wins, run not started.
//  start while busy is ignored. Reset mid-run: immediate return to reset values.
// TESTING
//  STOP: start=0, step=3, range [0,10], cnt=0, ready=1 -> 0,3,6,9; last on 9; done 1 cycle later.
//  STOP negative: start=5, step=-2, range [-3,5] -> 5,3,1,-1,-3; last on -3.
//  WRAP: start=8, step=3, range [0,10], cnt=5 -> 8,0,3,6,9; last on 9.
//  BOUNCE: start=0, step=4, range [0,10], cnt=6 -> 0,4,8,4,0,4; last on final 4.
//  Backpressure: ready low 3 cycles on beat 2 -> out_data/out_last stable; no beat lost or duplicated.
//  Error: step=0 -> 2 cycles after start, done=err=1 for one cycle; out_valid never high.
//  Abort: abort after 2nd beat -> out_valid=0 next cycle, IDLE, no done; a new start works normally.

Source files
------------

// File: rtl/seq_gen_stream_if.sv
// Valid/ready stream that carries one signed sequence value per beat.
// The master drives valid/data/last and the consumer drives ready.
interface seq_gen_stream_if #(
    parameter int WIDTH = 32
);
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/seq_gen_stream.sv
// Arithmetic sequence generator (STOP/WRAP/BOUNCE) with an optional beat limit,
// backpressure, abort and config checking, streaming over seq_gen_stream_if.
module seq_gen_stream #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [1:0]              mode,
    input  logic signed [WIDTH-1:0] start_value,
    input  logic signed [WIDTH-1:0] step,
    input  logic signed [WIDTH-1:0] range_min,
    input  logic signed [WIDTH-1:0] range_max,
    input  logic [CNT_W-1:0]        count_max,
    seq_gen_stream_if.master        stream,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [1:0] MODE_STOP   = 2'd0;
    localparam logic [1:0] MODE_WRAP   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    state_t                  state;
    logic [1:0]              mode_r;
    logic signed [WIDTH-1:0] start_r, step_r, min_r, max_r, cur;
    logic [CNT_W-1:0]        cnt_max_r, beats;
    logic                    dir;

    logic signed [WIDTH:0]   step_x, min_x, max_x, cur_x, delta, nxt, alt, b_x, b_nxt;
    logic signed [WIDTH-1:0] adv_val, b_val;
    logic                    adv_dir, b_dir, nxt_out, alt_out, next_last, cfg_err;
    logic [CNT_W-1:0]        beats_inc, b_beats;

    // Successor of cur in WIDTH+1 bits, then the last flag of whichever beat is
    // presented next (the first beat when leaving LOAD, the successor otherwise).
    always_comb begin
        step_x  = {step_r[WIDTH-1], step_r};
        min_x   = {min_r[WIDTH-1], min_r};
        max_x   = {max_r[WIDTH-1], max_r};
        cur_x   = {cur[WIDTH-1], cur};
        delta   = dir ? -step_x : step_x;
        nxt     = cur_x + delta;
        alt     = cur_x - delta;
        nxt_out = (nxt < min_x) || (nxt > max_x);
        alt_out = (alt < min_x) || (alt > max_x);
        adv_val = nxt[WIDTH-1:0];
        adv_dir = dir;
        case (mode_r)
            MODE_WRAP: begin
                if (nxt > max_x)
                    adv_val = min_r;
                else if (nxt < min_x)
                    adv_val = max_r;
            end
            MODE_BOUNCE: begin
                if (nxt_out) begin
                    adv_dir = ~dir;
                    adv_val = alt_out ? cur : alt[WIDTH-1:0];
                end
            end
            default: ;
        endcase
        beats_inc = (beats == '1) ? beats : beats + CNT_W'(1);

        if (state == S_LOAD) begin
            b_val   = start_r;
            b_dir   = 1'b0;
            b_beats = '0;
        end else begin
            b_val   = adv_val;
            b_dir   = adv_dir;
            b_beats = beats_inc;
        end
        b_x       = {b_val[WIDTH-1], b_val};
        b_nxt     = b_x + (b_dir ? -step_x : step_x);
        next_last = ((mode_r == MODE_STOP) && ((b_nxt < min_x) || (b_nxt > max_x))) ||
                    ((cnt_max_r != '0) && (b_beats == cnt_max_r - CNT_W'(1)));

        cfg_err = (step_r == '0) || (mode_r == MODE_RSVD) || (min_r > max_r) ||
                  (start_r < min_r) || (start_r > max_r);
    end

    // Control FSM; abort outranks every transition and suppresses the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            mode_r           <= '0;
            start_r          <= '0;
            step_r           <= '0;
            min_r            <= '0;
            max_r            <= '0;
            cnt_max_r        <= '0;
            cur              <= '0;
            dir              <= 1'b0;
            beats            <= '0;
            stream.out_valid <= 1'b0;
            stream.out_data  <= '0;
            stream.out_last  <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else if (abort) begin
            state            <= S_IDLE;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_r    <= mode;
                        start_r   <= start_value;
                        step_r    <= step;
                        min_r     <= range_min;
                        max_r     <= range_max;
                        cnt_max_r <= count_max;
                        busy      <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cfg_err) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        cur              <= start_r;
                        dir              <= 1'b0;
                        beats            <= '0;
                        stream.out_valid <= 1'b1;
                        stream.out_data  <= start_r;
                        stream.out_last  <= next_last;
                        state            <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stream.out_valid && stream.out_ready) begin
                        if (stream.out_last) begin
                            stream.out_valid <= 1'b0;
                            stream.out_last  <= 1'b0;
                            busy             <= 1'b0;
                            done             <= 1'b1;
                            state            <= S_DONE;
                        end else begin
                            cur             <= adv_val;
                            dir             <= adv_dir;
                            beats           <= beats_inc;
                            stream.out_data <= adv_val;
                            stream.out_last <= next_last;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_stream.sv
// Directed bench for seq_gen_stream: mode sequences, backpressure, config error,
// abort and start/abort collision, all against hand-computed values.
module tb_seq_gen_stream;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    abort = 1'b0;
    logic [1:0]              mode = '0;
    logic signed [WIDTH-1:0] start_value = '0;
    logic signed [WIDTH-1:0] step = '0;
    logic signed [WIDTH-1:0] range_min = '0;
    logic signed [WIDTH-1:0] range_max = '0;
    logic [CNT_W-1:0]        count_max = '0;
    logic                    busy, done, err;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    seq_gen_stream_if #(.WIDTH(WIDTH)) sif ();

    seq_gen_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .start_value(start_value),
        .step       (step),
        .range_min  (range_min),
        .range_max  (range_max),
        .count_max  (count_max),
        .stream     (sif.master),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint got, input longint expected);
        checks++;
        if (got !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then scramble the config to prove it was latched.
    task automatic applyStimulus(input int sv, input int st, input int lo, input int hi,
                                 input int cnt, input int md);
        start_value = sv;
        step        = st;
        range_min   = lo;
        range_max   = hi;
        count_max   = CNT_W'(cnt);
        mode        = 2'(md);
        start       = 1'b1;
        tick();
        start       = 1'b0;
        start_value = 32'sd1000;
        step        = '0;
        range_min   = 32'sd50;
        range_max   = -32'sd50;
        count_max   = 16'd1;
        mode        = 2'd3;
        checkOutput("busy_load", busy, 1);
        checkOutput("valid_load", sif.out_valid, 0);
    endtask

    // Collect exp_q with ready high, optionally stalling three cycles on one beat.
    task automatic receiveBeats(input int stall_beat);
        int idx = 0;
        int budget = 0;
        int last_idx = exp_q.size() - 1;
        sif.out_ready = 1'b1;
        while (idx < exp_q.size() && budget < 200) begin
            if (sif.out_valid) begin
                if (idx == stall_beat) begin
                    sif.out_ready = 1'b0;
                    repeat (3) begin
                        tick();
                        checkOutput("stall_valid", sif.out_valid, 1);
                        checkOutput("stall_data", sif.out_data, exp_q[idx]);
                        checkOutput("stall_last", sif.out_last, (idx == last_idx) ? 1 : 0);
                    end
                    sif.out_ready = 1'b1;
                end
                checkOutput($sformatf("data%0d", idx), sif.out_data, exp_q[idx]);
                checkOutput($sformatf("last%0d", idx), sif.out_last, (idx == last_idx) ? 1 : 0);
                idx++;
            end
            tick();
            budget++;
        end
        checkOutput("beat_count", idx, exp_q.size());
        checkOutput("done_pulse", done, 1);
        checkOutput("err_clean", err, 0);
        checkOutput("valid_after", sif.out_valid, 0);
        checkOutput("busy_after", busy, 0);
        tick();
        checkOutput("done_clear", done, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        sif.out_ready = 1'b1;
        repeat (2) tick();
        checkOutput("rst_valid", sif.out_valid, 0);
        checkOutput("rst_data", sif.out_data, 0);
        checkOutput("rst_last", sif.out_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] STOP ascending");
        applyStimulus(0, 3, 0, 10, 0, 0);
        exp_q = '{0, 3, 6, 9};
        receiveBeats(-1);

        $display("[TB] STOP descending");
        applyStimulus(5, -2, -3, 5, 0, 0);
        exp_q = '{5, 3, 1, -1, -3};
        receiveBeats(-1);

        $display("[TB] WRAP with beat limit");
        applyStimulus(8, 3, 0, 10, 5, 1);
        exp_q = '{8, 0, 3, 6, 9};
        receiveBeats(-1);

        $display("[TB] BOUNCE with beat limit");
        applyStimulus(0, 4, 0, 10, 6, 2);
        exp_q = '{0, 4, 8, 4, 0, 4};
        receiveBeats(-1);

        $display("[TB] WRAP with backpressure on beat 2");
        applyStimulus(8, 3, 0, 10, 5, 1);
        exp_q = '{8, 0, 3, 6, 9};
        receiveBeats(2);

        $display("[TB] config error step=0");
        applyStimulus(2, 0, 0, 10, 0, 0);
        checkOutput("err_done_early", done, 0);
        tick();
        checkOutput("err_done", done, 1);
        checkOutput("err_flag", err, 1);
        checkOutput("err_valid", sif.out_valid, 0);
        checkOutput("err_busy", busy, 0);
        tick();
        checkOutput("err_done_clear", done, 0);
        checkOutput("err_flag_clear", err, 0);
        checkOutput("err_valid_idle", sif.out_valid, 0);

        $display("[TB] start and abort together");
        start_value = 0; step = 1; range_min = 0; range_max = 20; count_max = '0; mode = 2'd0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkOutput("collide_busy", busy, 0);
        tick();
        checkOutput("collide_valid", sif.out_valid, 0);

        $display("[TB] abort after second beat");
        applyStimulus(0, 1, 0, 20, 0, 0);
        tick();
        checkOutput("abort_beat0", sif.out_data, 0);
        tick();
        checkOutput("abort_beat1", sif.out_data, 1);
        checkOutput("abort_valid_pre", sif.out_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_valid", sif.out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        tick();
        checkOutput("abort_done_late", done, 0);

        $display("[TB] restart after abort");
        applyStimulus(0, 4, 0, 10, 6, 2);
        exp_q = '{0, 4, 8, 4, 0, 4};
        receiveBeats(-1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
